// File: rtl/pc_fetch.sv
// Program counter and instruction fetch unit.
// Issues one fetch at a time, holds the returned word for decode, and computes
// the next pc from sequential, branch, jal and jalr sources when decode accepts.
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   - a misaligned redirect target parks the unit in a sticky trap state.
//   undefined - target bits [1:0] are forced to zero and fetch continues.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [31:0] trap_addr
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StTrap  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_instr;
  logic [31:0] w_instr_next;

  logic [31:0] w_seq_pc;
  logic [31:0] w_rel_pc;
  logic [31:0] w_jalr_pc;
  logic [31:0] w_target;
  logic        w_accept;

  // Redirect inputs only matter in HOLD with an accept; everything else ignores them.
  assign w_accept = (r_state == StHold) && instr_accept;

  // Address adders; all wrap modulo 2^32.
  always_comb begin
    w_seq_pc  = r_pc + 32'd4;
    w_rel_pc  = r_pc + imm;
    w_jalr_pc = (rs1_data + imm) & ~32'd1;
  end

  // Next-pc source select: jalr beats jal/branch, which beat sequential.
  always_comb begin
    w_target = w_seq_pc;
    if (jalr) begin
      w_target = w_jalr_pc;
    end else if (jal || branch_taken) begin
      w_target = w_rel_pc;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic        w_misaligned;
  logic [31:0] r_trap_addr;
  logic [31:0] w_trap_addr_next;

  assign w_misaligned = |w_target[1:0];
`endif

  // Next-state, next-pc and instruction capture.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
`ifdef PC_MISALIGN_TRAP_EN
    w_trap_addr_next = r_trap_addr;
`endif
    unique case (r_state)
      StFetch: begin
        if (imem_ready) begin
          w_instr_next = imem_rdata;
          w_state_next = StHold;
        end
      end
      StHold: begin
        if (w_accept) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (w_misaligned) begin
            // pc stays on the offending instruction for debug visibility.
            w_trap_addr_next = w_target;
            w_state_next     = StTrap;
          end else begin
            w_pc_next    = w_target;
            w_state_next = StFetch;
          end
`else
          w_pc_next    = w_target & ~32'd3;
          w_state_next = StFetch;
`endif
        end
      end
      StTrap: begin
        w_state_next = StTrap;
      end
      default: begin
        w_state_next = StFetch;
      end
    endcase
  end

  // State registers; synchronous reset wins over any fetch, hold or trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFetch;
      r_pc    <= RESET_PC;
      r_instr <= NopInstr;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Offending target address, captured on entry to the trap state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trap_addr <= 32'h0000_0000;
    end else begin
      r_trap_addr <= w_trap_addr_next;
    end
  end

  assign trap      = (r_state == StTrap);
  assign trap_addr = r_trap_addr;
`else
  assign trap      = 1'b0;
  assign trap_addr = 32'h0000_0000;
`endif

  assign imem_req    = (r_state == StFetch);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == StHold);
  assign pc          = r_pc;
  assign pc_plus4    = w_seq_pc;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch with hand-computed expectations.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch_taken;
  logic        jal;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [31:0] trap_addr;

  int n_total = 0;
  int n_bad   = 0;

  pc_fetch #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .branch_taken (branch_taken),
    .jal          (jal),
    .jalr         (jalr),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .trap         (trap),
    .trap_addr    (trap_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are register-driven so sampling 1 time unit later is safe.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ready   = 1'b0;
    imem_rdata   = 32'h0;
    instr_accept = 1'b0;
    branch_taken = 1'b0;
    jal          = 1'b0;
    jalr         = 1'b0;
    imm          = 32'h0;
    rs1_data     = 32'h0;
  endtask

  // One-cycle fetch from FETCH to HOLD.
  task automatic fetch(input logic [31:0] word);
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    clear_inputs();
  endtask

  // Accept the held instruction with the given redirect controls.
  task automatic accept(input logic bt, input logic j, input logic jr,
                        input logic [31:0] im, input logic [31:0] rs);
    instr_accept = 1'b1;
    branch_taken = bt;
    jal          = j;
    jalr         = jr;
    imm          = im;
    rs1_data     = rs;
    tick();
    clear_inputs();
  endtask

  initial begin
    // Reset with a live imem_ready and junk redirects; all must be discarded.
    rst          = 1'b1;
    imem_ready   = 1'b1;
    imem_rdata   = 32'hDEAD_BEEF;
    instr_accept = 1'b1;
    branch_taken = 1'b1;
    jal          = 1'b0;
    jalr         = 1'b0;
    imm          = 32'h40;
    rs1_data     = 32'h0;
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_valid", instr_valid, 32'd0);
    check("rst_req", imem_req, 32'd1);
    check("rst_trap", trap, 32'd0);
    check("rst_trap_addr", trap_addr, 32'h0);

    rst = 1'b0;
    clear_inputs();
    check("req_after_rst", imem_req, 32'd1);

    // Sequential fetch 0, 4, 8.
    fetch(32'hAAAA_0001);
    check("seq_valid", instr_valid, 32'd1);
    check("seq_instr", instr, 32'hAAAA_0001);
    check("seq_req_hold", imem_req, 32'd0);
    check("seq_pc0", pc, 32'h0);
    check("seq_plus4", pc_plus4, 32'h4);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("seq_addr4", imem_addr, 32'h4);
    check("seq_valid_fetch", instr_valid, 32'd0);
    check("seq_req_fetch", imem_req, 32'd1);
    fetch(32'h2);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("seq_addr8", imem_addr, 32'h8);

    // Branch taken / not taken from 0x100 with a negative offset.
    fetch(32'h3);
    accept(1'b0, 1'b1, 1'b0, 32'hF8, 32'h0);
    check("jal_to_100", imem_addr, 32'h100);
    fetch(32'h4);
    accept(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
    check("br_taken", imem_addr, 32'h0F0);
    fetch(32'h5);
    accept(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("jal_back_100", imem_addr, 32'h100);
    fetch(32'h6);
    accept(1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
    check("br_not_taken", imem_addr, 32'h104);

    // jalr beats jal, bit0 cleared.
    fetch(32'h7);
    accept(1'b0, 1'b1, 1'b0, 32'hFC, 32'h0);
    fetch(32'h8);
    check("pc_200", pc, 32'h200);
    check("plus4_204", pc_plus4, 32'h204);
    accept(1'b0, 1'b1, 1'b1, 32'h4, 32'h1001);
    check("jalr_wins", imem_addr, 32'h1004);

    // Memory stall: accept and redirects in FETCH must have no effect.
    instr_accept = 1'b1;
    jalr         = 1'b1;
    rs1_data     = 32'h8000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", imem_addr, 32'h1004);
      check("stall_valid", instr_valid, 32'd0);
      check("stall_req", imem_req, 32'd1);
    end
    clear_inputs();
    fetch(32'h1234_5678);
    check("stall_done_valid", instr_valid, 32'd1);
    check("stall_done_instr", instr, 32'h1234_5678);

    // Decode back-pressure: redirects without accept are ignored.
    branch_taken = 1'b1;
    imm          = 32'h40;
    imem_ready   = 1'b1;
    imem_rdata   = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_instr", instr, 32'h1234_5678);
      check("bp_pc", pc, 32'h1004);
      check("bp_valid", instr_valid, 32'd1);
    end
    clear_inputs();

    // Address wrap at the top of the space.
    accept(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC);
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h9);
    check("wrap_plus4", pc_plus4, 32'h0);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_addr0", imem_addr, 32'h0);

    // Misaligned target from pc=0x10, jal imm=6.
    fetch(32'hA);
    accept(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("pc_10", imem_addr, 32'h10);
    fetch(32'hB);
    accept(1'b0, 1'b1, 1'b0, 32'h6, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    check("trap_flag", trap, 32'd1);
    check("trap_addr", trap_addr, 32'h16);
    check("trap_req", imem_req, 32'd0);
    check("trap_valid", instr_valid, 32'd0);
    check("trap_pc", pc, 32'h10);
    imem_ready   = 1'b1;
    instr_accept = 1'b1;
    jal          = 1'b1;
    imm          = 32'h8;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("trap_sticky", trap, 32'd1);
      check("trap_req_held", imem_req, 32'd0);
      check("trap_pc_held", pc, 32'h10);
    end
    clear_inputs();
`else
    check("mis_addr", imem_addr, 32'h14);
    check("mis_trap", trap, 32'd0);
    check("mis_trap_addr", trap_addr, 32'h0);
    fetch(32'hC);
    accept(1'b0, 1'b0, 1'b1, 32'h1, 32'h22);
    check("mis_jalr", imem_addr, 32'h20);
`endif

    // Reset from wherever we are (trap in the trap build).
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_pc", pc, 32'h0);
    check("rst2_trap", trap, 32'd0);
    check("rst2_req", imem_req, 32'd1);

    // Reset in HOLD with accept and branch pending.
    fetch(32'h55);
    check("hold_valid", instr_valid, 32'd1);
    accept(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    fetch(32'h66);
    check("hold_pc40", pc, 32'h40);
    rst          = 1'b1;
    instr_accept = 1'b1;
    branch_taken = 1'b1;
    imm          = 32'h80;
    imem_ready   = 1'b1;
    imem_rdata   = 32'h77;
    tick();
    rst = 1'b0;
    clear_inputs();
    check("rsthold_pc", pc, 32'h0);
    check("rsthold_valid", instr_valid, 32'd0);
    check("rsthold_req", imem_req, 32'd1);
    check("rsthold_instr", instr, 32'h0000_0013);
    tick();
    check("post_rst_req", imem_req, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL provide clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL provide rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL provide imem_addr  output  32  fetch address; always equals pc.
REQ-006 SHALL provide imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-007 SHALL provide imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL provide instr  output  32  held instruction for decode.
REQ-009 SHALL provide instr_valid  output  1  instr and pc are valid.
REQ-010 SHALL provide instr_accept  input  1  decode/execute consumes instr; redirect inputs sampled this cycle.
REQ-011 SHALL provide branch_taken  input  1  conditional-branch result from the branch comparator.
REQ-012 SHALL provide jal  input  1, jalr  input  1  unconditional jump controls.
REQ-013 SHALL provide imm  input  32  sign-extended offset; rs1_data  input  32  jalr base.
REQ-014 SHALL provide pc  output  32  address of current instruction; pc_plus4  output  32  pc+4, link value.
REQ-015 SHALL provide trap  output  1  sticky misaligned-target flag; trap_addr  output  32  offending target.

Function
REQ-016 SHALL implement states FETCH, HOLD, TRAP.
REQ-017 FETCH: imem_req=1; on imem_ready capture imem_rdata into instr, go HOLD; otherwise stay FETCH with imem_addr stable.
REQ-018 HOLD: instr_valid=1, imem_req=0; on instr_accept load next pc and go FETCH (or TRAP per REQ-022); otherwise hold instr and pc unchanged.
REQ-019 Next-pc priority: jalr -> (rs1_data+imm) with bit0 cleared; else jal or branch_taken -> pc+imm; else pc+4.
REQ-020 All address adds SHALL be 32-bit modulo; wrap at 32'hFFFF_FFFC+4 -> 32'h0000_0000 without error.
REQ-021 branch_taken, jal, jalr, imm, rs1_data SHALL be ignored whenever instr_accept=0 or state is not HOLD.
REQ-022 Target with bits[1:0]!=0 handled per REQ-029/030.
REQ-023 TRAP: imem_req=0, instr_valid=0, trap=1, pc frozen; exit only by rst.
REQ-024 instr_accept in FETCH or TRAP SHALL have no effect.
REQ-025 Fetch latency: one cycle minimum from FETCH entry with imem_ready=1 to instr_valid=1.

Reset
REQ-026 On rst=1 at a clock edge: state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, trap=0, trap_addr=0.
REQ-027 Reset SHALL take precedence over any in-flight fetch, hold or trap; an imem_ready in the reset cycle SHALL be discarded.
REQ-028 imem_req SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 With PC_MISALIGN_TRAP_EN defined: misaligned target on accept -> state TRAP, trap_addr=target, pc unchanged.
REQ-030 Without PC_MISALIGN_TRAP_EN: target bits[1:0] forced to 2'b00, fetch continues; trap and trap_addr tied 0; TRAP state unreachable.

Verification
REQ-031 Reset, RESET_PC=0, imem_ready=1 always -> imem_addr 0,4,8 on successive fetches with instr_accept=1, no redirects.
REQ-032 pc=0x100, imm=0xFFFF_FFF0, branch_taken=1 on accept -> next imem_addr=0x0F0; same with branch_taken=0 -> 0x104.
REQ-033 pc=0x200, jalr=1, jal=1, rs1_data=0x1001, imm=4 -> next imem_addr=0x1004 (jalr wins, bit0 cleared); pc_plus4=0x204 before accept.
REQ-034 imem_ready low 3 cycles then high -> imem_addr stable, instr_valid=0 until the cycle after ready; instr_accept held low 2 cycles -> instr, pc unchanged.
REQ-035 PC_MISALIGN_TRAP_EN defined, pc=0x10, jal=1, imm=6 -> trap=1, trap_addr=0x16, imem_req=0 until rst; undefined -> next imem_addr=0x14, trap=0.
REQ-036 rst asserted in HOLD with instr_accept=1 and branch_taken=1 -> next cycle pc=RESET_PC, instr_valid=0, imem_req=1.
